// File: rtl/imhotep_pkg.sv
// Shared core types: LSU operation encoding, LSU state and access-size helpers.
package imhotep_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RFADDR = 5;

  typedef enum logic [3:0] {
    LSU_NOP,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } op_lsu_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [1:0] lsu_size(input op_lsu_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return SIZE_BYTE;
      LSU_LH, LSU_LHU, LSU_SH: return SIZE_HALF;
      default:                 return SIZE_WORD;
    endcase
  endfunction

  function automatic logic lsu_is_store(input op_lsu_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends the addressed byte/half/word of a load response.
module lsu_load_align
  import imhotep_pkg::*;
(
  input  op_lsu_e         op_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin
    shifted  = rdata_i >> {offset_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    case (op_i)
      LSU_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: result_o = {24'h0, byte_sel};
      LSU_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit on a req/gnt/rvalid data-memory port.
module load_store_unit
  import imhotep_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  op_lsu_e           op_lsu_i,
  input  logic [XLEN-1:0]   base_i,
  input  logic [XLEN-1:0]   offset_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [RFADDR-1:0] rd_addr_i,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  input  logic              data_err_i,
  output logic              wb_valid_o,
  output logic [RFADDR-1:0] wb_addr_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              done_o,
  output logic              err_o
);

  lsu_state_e        state_q;
  op_lsu_e           op_q;
  logic [1:0]        ea_lo_q;
  logic [RFADDR-1:0] rd_q;

  logic [XLEN-1:0] ea;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic            misaligned;
  logic            accept;
  logic [XLEN-1:0] load_result;

  assign ea     = base_i + offset_i;
  assign accept = valid_i && ready_o && (op_lsu_i != LSU_NOP);

  always_comb begin
    be_d       = 4'b1111;
    wdata_d    = wdata_i;
    misaligned = 1'b0;
    case (lsu_size(op_lsu_i))
      SIZE_BYTE: begin
        be_d    = 4'b0001 << ea[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_d       = ea[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{wdata_i[15:0]}};
        misaligned = ea[0];
      end
      default: misaligned = |ea[1:0];
    endcase
  end

  lsu_load_align u_load_align (
    .op_i     (op_q),
    .offset_i (ea_lo_q),
    .rdata_i  (data_rdata_i),
    .result_o (load_result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LSU_IDLE;
      op_q         <= LSU_NOP;
      ea_lo_q      <= 2'b00;
      rd_q         <= '0;
      ready_o      <= 1'b1;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      // Completion strobes are single-cycle.
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      wb_valid_o <= 1'b0;
      unique case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state_q      <= LSU_REQ;
              ready_o      <= 1'b0;
              data_req_o   <= 1'b1;
              data_we_o    <= lsu_is_store(op_lsu_i);
              data_be_o    <= be_d;
              data_addr_o  <= {ea[XLEN-1:2], 2'b00};
              data_wdata_o <= wdata_d;
              op_q         <= op_lsu_i;
              ea_lo_q      <= ea[1:0];
              rd_q         <= rd_addr_i;
            end
          end
        end
        LSU_REQ: begin
          if (data_gnt_i) begin
            state_q    <= LSU_WAIT;
            data_req_o <= 1'b0;
          end
        end
        LSU_WAIT: begin
          if (data_rvalid_i) begin
            state_q <= LSU_IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
            if (data_err_i) begin
              err_o <= 1'b1;
            end else if (!lsu_is_store(op_q) && (rd_q != '0)) begin
              wb_valid_o <= 1'b1;
              wb_addr_o  <= rd_q;
              wb_data_o  <= load_result;
            end
          end
        end
        default: begin
          state_q <= LSU_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expectations, monitors compare.
module tb_load_store_unit;
  import imhotep_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  op_lsu_e     op_lsu_i;
  logic [31:0] base_i, offset_i, wdata_i;
  logic [4:0]  rd_addr_i;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        done_o, err_o;

  always #5 clk_i = ~clk_i;

  load_store_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .op_lsu_i      (op_lsu_i),
    .base_i        (base_i),
    .offset_i      (offset_i),
    .wdata_i       (wdata_i),
    .rd_addr_i     (rd_addr_i),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .data_err_i    (data_err_i),
    .wb_valid_o    (wb_valid_o),
    .wb_addr_o     (wb_addr_o),
    .wb_data_o     (wb_data_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic        wb;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Request monitor: every REQ cycle must present the expected, stable request.
  always @(negedge clk_i) begin
    req_t r;
    if (!rst_i && data_req_o) begin
      if (req_q.size() == 0) begin
        check1("unexpected_req", data_req_o, 1'b0);
      end else begin
        r = req_q[0];
        check("req_addr", data_addr_o, r.addr);
        check("req_be", {28'h0, data_be_o}, {28'h0, r.be});
        check1("req_we", data_we_o, r.we);
        if (r.chk_wdata) check("req_wdata", data_wdata_o, r.wdata);
        if (data_gnt_i) void'(req_q.pop_front());
      end
    end
  end

  // Response monitor: every done pulse consumes one expected completion.
  always @(negedge clk_i) begin
    resp_t e;
    if (!rst_i) begin
      if (done_o) begin
        if (resp_q.size() == 0) begin
          check1("unexpected_done", done_o, 1'b0);
        end else begin
          e = resp_q.pop_front();
          check1("resp_err", err_o, e.err);
          check1("resp_wb_valid", wb_valid_o, e.wb);
          if (e.wb) begin
            check("resp_wb_addr", {27'h0, wb_addr_o}, {27'h0, e.wb_addr});
            check("resp_wb_data", wb_data_o, e.wb_data);
          end
        end
      end else if (wb_valid_o || err_o) begin
        check("stray_pulse", {30'h0, wb_valid_o, err_o}, 32'h0);
      end
    end
  end

  task automatic scramble();
    valid_i   = 1'b0;
    base_i    = $urandom;
    offset_i  = $urandom;
    wdata_i   = $urandom;
    rd_addr_i = 5'($urandom);
  endtask

  task automatic present(input op_lsu_e op, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd);
    int t;
    t = 0;
    while (!ready_o && t < 50) begin
      @(posedge clk_i); #1;
      t++;
    end
    check1("ready_before_accept", ready_o, 1'b1);
    valid_i   = 1'b1;
    op_lsu_i  = op;
    base_i    = base;
    offset_i  = off;
    wdata_i   = wd;
    rd_addr_i = rd;
    @(posedge clk_i); #1;
    scramble();
  endtask

  task automatic run_op(input op_lsu_e op, input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wd, input logic [4:0] rd, input int gnt_dly,
                        input logic [31:0] rdata, input logic berr, input logic mis,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic e_chkw, input logic e_wb,
                        input logic [31:0] e_wbdata);
    int   t;
    logic is_st;
    is_st = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    if (!mis) req_q.push_back('{e_addr, e_be, is_st, e_wdata, e_chkw});
    resp_q.push_back('{(mis | berr), e_wb, rd, e_wbdata});
    present(op, base, off, wd, rd);
    if (mis) begin
      check1("mis_no_req", data_req_o, 1'b0);
      check1("mis_ready", ready_o, 1'b1);
      @(posedge clk_i); #1;
      check1("mis_ready_after", ready_o, 1'b1);
    end else begin
      t = 0;
      while (!data_req_o && t < 20) begin
        @(posedge clk_i); #1;
        t++;
      end
      check1("req_seen", data_req_o, 1'b1);
      repeat (gnt_dly) begin
        @(posedge clk_i); #1;
      end
      data_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = rdata;
      data_err_i    = berr;
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      data_rdata_i  = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i         = 1'b1;
    op_lsu_i      = LSU_NOP;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
    scramble();
    repeat (2) @(posedge clk_i);
    #1;
    check1("rst_ready", ready_o, 1'b1);
    check1("rst_req", data_req_o, 1'b0);
    check1("rst_we", data_we_o, 1'b0);
    check("rst_be", {28'h0, data_be_o}, 32'h0);
    check("rst_addr", data_addr_o, 32'h0);
    check("rst_wdata", data_wdata_o, 32'h0);
    check1("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check1("rst_done", done_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // NOP is never accepted.
    valid_i  = 1'b1;
    op_lsu_i = LSU_NOP;
    @(posedge clk_i); #1;
    check1("nop_ready", ready_o, 1'b1);
    check1("nop_no_req", data_req_o, 1'b0);
    scramble();

    //     op       base          off     wdata         rd gnt rdata         berr mis
    //     e_addr        be     e_wdata       chkw wb  wb_data
    run_op(LSU_LW,  32'h1000, 32'h8, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0, 1'b0,
           32'h1008, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    run_op(LSU_LB,  32'h1000, 32'h3, 32'h0, 5'd6, 1, 32'h80FFFF00, 1'b0, 1'b0,
           32'h1000, 4'h8, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
    run_op(LSU_LBU, 32'h1000, 32'h3, 32'h0, 5'd6, 0, 32'h80FFFF00, 1'b0, 1'b0,
           32'h1000, 4'h8, 32'h0, 1'b0, 1'b1, 32'h00000080);
    run_op(LSU_LB,  32'h1000, 32'h1, 32'h0, 5'd13, 0, 32'h00007F00, 1'b0, 1'b0,
           32'h1000, 4'h2, 32'h0, 1'b0, 1'b1, 32'h0000007F);
    run_op(LSU_SH,  32'h2000, 32'h2, 32'h1234ABCD, 5'd4, 3, 32'h0, 1'b0, 1'b0,
           32'h2000, 4'hC, 32'hABCDABCD, 1'b1, 1'b0, 32'h0);
    run_op(LSU_SB,  32'h8000, 32'h1, 32'h000000A5, 5'd1, 0, 32'h0, 1'b0, 1'b0,
           32'h8000, 4'h2, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0);
    run_op(LSU_SW,  32'h8000, 32'h4, 32'h01020304, 5'd1, 1, 32'h0, 1'b0, 1'b0,
           32'h8004, 4'hF, 32'h01020304, 1'b1, 1'b0, 32'h0);
    run_op(LSU_LW,  32'h3000, 32'h1, 32'h0, 5'd5, 0, 32'h0, 1'b0, 1'b1,
           32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op(LSU_SH,  32'h3000, 32'h3, 32'h0, 5'd0, 0, 32'h0, 1'b0, 1'b1,
           32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op(LSU_LH,  32'h4000, 32'h0, 32'h0, 5'd8, 1, 32'h5555AAAA, 1'b1, 1'b0,
           32'h4000, 4'h3, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op(LSU_LW,  32'h5000, 32'h0, 32'h0, 5'd0, 0, 32'h12345678, 1'b0, 1'b0,
           32'h5000, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op(LSU_LHU, 32'h9000, 32'h2, 32'h0, 5'd10, 0, 32'h80017FFF, 1'b0, 1'b0,
           32'h9000, 4'hC, 32'h0, 1'b0, 1'b1, 32'h00008001);
    run_op(LSU_LH,  32'h9000, 32'h2, 32'h0, 5'd11, 0, 32'h80017FFF, 1'b0, 1'b0,
           32'h9000, 4'hC, 32'h0, 1'b0, 1'b1, 32'hFFFF8001);
    run_op(LSU_LH,  32'h9000, 32'h0, 32'h0, 5'd12, 0, 32'h80017FFF, 1'b0, 1'b0,
           32'h9000, 4'h3, 32'h0, 1'b0, 1'b1, 32'h00007FFF);

    // Reset while waiting for rvalid: the late response must be dropped.
    req_q.push_back('{32'h6000, 4'hF, 1'b0, 32'h0, 1'b0});
    present(LSU_LW, 32'h6000, 32'h0, 32'h0, 5'd7);
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0;
    rst_i      = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check1("mid_rst_ready", ready_o, 1'b1);
    check1("mid_rst_req", data_req_o, 1'b0);
    check1("mid_rst_done", done_o, 1'b0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h11111111;
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    check1("stale_rvalid_done", done_o, 1'b0);
    check1("stale_rvalid_wb", wb_valid_o, 1'b0);
    check1("stale_rvalid_err", err_o, 1'b0);
    check1("stale_rvalid_ready", ready_o, 1'b1);

    run_op(LSU_LW,  32'h7000, 32'h4, 32'h0, 5'd3, 0, 32'h12345678, 1'b0, 1'b0,
           32'h7004, 4'hF, 32'h0, 1'b0, 1'b1, 32'h12345678);
    run_op(LSU_LW,  32'hFFFFFFFC, 32'h8, 32'h0, 5'd9, 0, 32'hCAFEF00D, 1'b0, 1'b0,
           32'h00000004, 4'hF, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

    repeat (3) @(posedge clk_i);
    #1;
    check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    check("req_queue_drained", 32'(req_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the load/store operations (op_lsu_e) produced by the instruction decoder. Accepts one operation at a time.
- Forms the effective address, issues a single-beat request on the data-memory req/gnt/rvalid interface, and formats load data for register-file writeback.
- Flags misaligned accesses and bus errors.
- Sits in the execute stage between the decoder/RF and data memory.

Parameters:
- XLEN, 32, datapath and address width (from imhotep_pkg)
- RFADDR, 5, register-file address width (from imhotep_pkg)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  operation presented
- ready_o  out  1  LSU idle; accept = valid_i && ready_o
- op_lsu_i  in  op_lsu_e  operation; LSU_NOP is ignored
- base_i  in  XLEN  rs1 value
- offset_i  in  XLEN  sign-extended immediate
- wdata_i  in  XLEN  rs2 value (stores)
- rd_addr_i  in  RFADDR  load destination
- data_req_o  out  1  memory request
- data_we_o  out  1  1 = store
- data_be_o  out  4  byte enables
- data_addr_o  out  XLEN  word-aligned address
- data_wdata_o  out  XLEN  lane-replicated store data
- data_gnt_i  in  1  request accepted
- data_rvalid_i  in  1  response valid
- data_rdata_i  in  XLEN  load data
- data_err_i  in  1  bus error, qualified by rvalid
- wb_valid_o  out  1  one-cycle writeback strobe
- wb_addr_o  out  RFADDR  writeback register
- wb_data_o  out  XLEN  formatted load result
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse, coincident with done_o

Behaviour:
- Reset: state IDLE. All outputs 0 except ready_o=1.
- Effective address: ea = base_i + offset_i, mod 2^32; wrap-around is legal.
- Accept rule: an accept is valid_i && ready_o && op_lsu_i != LSU_NOP. Inputs are sampled only at accept; upstream may change them afterwards. valid_i is ignored when ready_o=0.
- Misalignment:
  - LH/LHU/SH require ea[0]=0.
  - LW/SW require ea[1:0]=0.
  - On a misaligned accept there is no memory request. done_o and err_o pulse the next cycle. wb_valid_o stays 0. State stays IDLE with ready_o=1 throughout.
- FSM:
  - IDLE -> REQ on an aligned accept. ready_o=0 from the next cycle.
  - REQ: data_req_o=1. addr, we, be and wdata are registered and held stable until data_gnt_i. On gnt -> WAIT, and data_req_o drops the following cycle.
  - WAIT: data_rvalid_i completes the access (earliest one cycle after gnt). On rvalid -> IDLE; done_o pulses next cycle.
  - data_rvalid_i is ignored in IDLE and REQ. data_gnt_i is ignored outside REQ.
- Address and enables:
  - data_addr_o = {ea[31:2], 2'b00}.
  - Byte: be = 4'b0001 << ea[1:0]; wdata = {4{rs2[7:0]}}.
  - Half: be = ea[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - Word: be = 4'b1111; wdata = rs2.
  - Loads drive the same be pattern with data_we_o=0.
- Load format:
  - LB/LBU take byte ea[1:0].
  - LH/LHU take half ea[1].
  - Sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through.
- Writeback:
  - On load completion without error, wb_valid_o=1 for exactly one cycle, alongside done_o, with wb_addr_o/wb_data_o registered.
  - wb_valid_o is suppressed when rd_addr=0.
  - Stores never write back.
- Bus error: data_err_i with rvalid gives err_o=1 and done_o=1, with no writeback.
- Readiness after completion: ready_o is 1 in the same cycle as done_o, so back-to-back operations are allowed. Minimum occupancy is 3 cycles per access (accept, REQ with gnt, WAIT with rvalid).
- Reset mid-operation: any state -> IDLE. data_req_o=0 after the edge; pending pulses are cleared. A stale rvalid arriving afterwards is ignored.

Decomposition:
- imhotep_pkg holds:
  - op_lsu_e (already shared with the decoder)
  - the new lsu_state_e {LSU_IDLE, LSU_REQ, LSU_WAIT}
  - helper constants for access size (BYTE/HALF/WORD)
- One combinational sub-module, lsu_load_align, maps (op, ea[1:0], rdata) to the formatted result. It is reusable by a future cache.

Test Plan:
- LW, base=0x1000, off=0x8, gnt the same cycle as req, rvalid next cycle with rdata=0xDEADBEEF, rd=5 -> data_addr_o=0x1008, be=1111, wb_valid_o=1, wb_addr_o=5, wb_data_o=0xDEADBEEF, done_o one cycle.
- LB at ea=0x1003 with rdata=0x80FF_FF00, then LBU at the same address -> be=1000; wb_data_o=0xFFFFFF80, then 0x00000080.
- SH, ea=0x2002, rs2=0x1234ABCD, gnt delayed 3 cycles -> req/addr/be=1100/wdata=0xABCDABCD stable for all 4 REQ cycles; no wb_valid_o; done_o after rvalid.
- LW at ea=0x3001 -> no data_req_o; the next cycle done_o=1 and err_o=1; ready_o stays 1.
- LH with rvalid and data_err_i=1 -> err_o=1, done_o=1, wb_valid_o=0. Separately, LW with rd=0 -> done_o=1, wb_valid_o=0.
- rst_i asserted in WAIT, then rvalid arrives -> IDLE, ready_o=1, no wb/done/err pulse; the next LW completes normally. Also base=0xFFFFFFFC, off=8 -> data_addr_o=0x00000004.
